// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester identity.
package mem_arb_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between I-side and D-side requests.
// MEM_PORT_ARBITER_RR_EN selects round-robin on contention; otherwise D wins.
module mem_arb_pick
    import mem_arb_types::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_side
);

`ifndef MEM_PORT_ARBITER_RR_EN
    logic unused_last;
    assign unused_last = last_served;
`endif

    always_comb begin
        grant_valid = i_req | d_req;
        grant_side  = SIDE_I;
        if (d_req && !i_req) begin
            grant_side = SIDE_D;
        end else if (d_req && i_req) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            // Contention goes to whichever side was not served last.
            grant_side = (last_served == SIDE_I) ? SIDE_D : SIDE_I;
`else
            grant_side = SIDE_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the I-side and D-side requesters.
// Build option MEM_PORT_ARBITER_RR_EN: round-robin on contention instead of fixed D priority.
module mem_port_arbiter
    import mem_arb_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MBE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MBE_W-1:0]  d_mbe,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [MBE_W-1:0]  pmem_mbe,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state, state_n;
    logic       d_req;
    logic       grant_valid;
    logic       grant_side;
    logic       last_served;

    assign d_req = d_read | d_write;

    mem_arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_served (last_served),
        .grant_valid (grant_valid),
        .grant_side  (grant_side)
    );

`ifdef MEM_PORT_ARBITER_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_served <= SIDE_I;
        end else if (state == IDLE && grant_valid) begin
            last_served <= grant_side;
        end
    end
`else
    assign last_served = SIDE_I;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_n = (grant_side == SIDE_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // pmem_* are loaded once at grant and then frozen; requester inputs are
    // not looked at again until the arbiter is back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            pmem_mbe   <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid && grant_side == SIDE_D) begin
                        pmem_addr  <= d_addr;
                        pmem_wdata <= d_wdata;
                        pmem_mbe   <= d_mbe;
                        pmem_write <= d_write;
                        pmem_read  <= ~d_write;
                    end else if (grant_valid) begin
                        pmem_addr  <= i_addr;
                        pmem_wdata <= '0;
                        pmem_mbe   <= '0;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
                    end
                end
                I_BUSY: begin
                    if (pmem_resp) begin
                        i_rdata    <= pmem_rdata;
                        i_resp     <= 1'b1;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                D_BUSY: begin
                    if (pmem_resp) begin
                        d_rdata    <= pmem_rdata;
                        d_resp     <= 1'b1;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model, grant/response scoreboards.
// Honours MEM_PORT_ARBITER_RR_EN when predicting contention order.
module tb_mem_port_arbiter;

    localparam int GW = 70;  // {read, write, addr, wdata, mbe}
    localparam int RW = 33;  // {side, rdata}

`ifdef MEM_PORT_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_read = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_mbe = '0;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    logic        model_resp = 1'b0;
    logic [31:0] model_rdata = '0;
    logic        manual_resp = 1'b0;
    logic        mem_en = 1'b1;
    int          mem_lat = 2;
    int          lat_cnt = 0;

    logic [GW-1:0] gnt_q[$];
    logic [RW-1:0] exp_q[$];
    logic [GW-1:0] held = '0;
    logic          prev_strobe = 1'b0;
    bit            tb_last = 1'b0;  // 0 = I served last
    int            vectors = 0;
    int            errors = 0;

    assign pmem_resp  = model_resp | manual_resp;
    assign pmem_rdata = manual_resp ? 32'hBAD0_BAD0 : model_rdata;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_mbe      (d_mbe),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_mbe   (pmem_mbe),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h60) return 32'h0000_0013;
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    // Memory model: answers a strobe after mem_lat cycles with a one-cycle resp.
    always @(negedge clk) begin
        if (model_resp) begin
            model_resp = 1'b0;
        end else if (mem_en && (pmem_read || pmem_write)) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                model_resp  = 1'b1;
                model_rdata = mem_data(pmem_addr);
                lat_cnt     = 0;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Scoreboard: grants checked on strobe rise and while held; responses on pulse.
    always @(negedge clk) begin
        logic          strobe;
        logic [GW-1:0] obs;
        logic [RW-1:0] exp_r;
        strobe = pmem_read | pmem_write;
        obs    = {pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_mbe};
        if (strobe) check("strobe_excl", 128'(pmem_read & pmem_write), 128'd0);
        if (strobe && !prev_strobe) begin
            if (gnt_q.size() == 0) begin
                check("unexp_grant", 128'(obs), 128'd0);
            end else begin
                held = gnt_q.pop_front();
                check("grant", 128'(obs), 128'(held));
            end
        end else if (strobe) begin
            check("hold", 128'(obs), 128'(held));
        end
        prev_strobe = strobe;
        if (i_resp || d_resp) begin
            check("resp_excl", 128'(i_resp & d_resp), 128'd0);
            if (exp_q.size() == 0) begin
                check("spurious_resp", 128'({d_resp, i_resp}), 128'd0);
            end else begin
                exp_r = exp_q.pop_front();
                check("resp", 128'({d_resp, d_resp ? d_rdata : i_rdata}), 128'(exp_r));
            end
        end
    end

    task automatic run_single(input bit side, input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mbe, input int lat);
        bit done;
        done = 1'b0;
        @(negedge clk);
        mem_lat = lat;
        if (!side) begin
            i_read = 1'b1;
            i_addr = addr;
            gnt_q.push_back({1'b1, 1'b0, addr, 32'h0, 4'h0});
        end else begin
            d_read  = rd;
            d_write = wr;
            d_addr  = addr;
            d_wdata = wdata;
            d_mbe   = mbe;
            gnt_q.push_back({~wr, wr, addr, wdata, mbe});
        end
        exp_q.push_back({side, mem_data(addr)});
        tb_last = side;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) check("gnt_lat", 128'(pmem_read | pmem_write), 128'd1);
            if (side ? d_resp : i_resp) begin
                check("resp_lat", 128'(k), 128'(lat + 1));
                done = 1'b1;
                break;
            end
        end
        if (!done) check("resp_timeout", 128'd0, 128'd1);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic run_pair(input logic [31:0] ia, input logic [31:0] da);
        bit gi, gd, win;
        logic [GW-1:0] gi_e, gd_e;
        gi = 1'b0;
        gd = 1'b0;
        @(negedge clk);
        mem_lat = $urandom_range(1, 3);
        i_read  = 1'b1;
        i_addr  = ia;
        d_read  = 1'b1;
        d_addr  = da;
        d_wdata = 32'h0;
        d_mbe   = 4'hF;
        gi_e = {1'b1, 1'b0, ia, 32'h0, 4'h0};
        gd_e = {1'b1, 1'b0, da, 32'h0, 4'hF};
        win  = (RR && tb_last) ? 1'b0 : 1'b1;
        if (win) begin
            gnt_q.push_back(gd_e);
            gnt_q.push_back(gi_e);
            exp_q.push_back({1'b1, mem_data(da)});
            exp_q.push_back({1'b0, mem_data(ia)});
        end else begin
            gnt_q.push_back(gi_e);
            gnt_q.push_back(gd_e);
            exp_q.push_back({1'b0, mem_data(ia)});
            exp_q.push_back({1'b1, mem_data(da)});
        end
        tb_last = ~win;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (i_resp) begin i_read = 1'b0; gi = 1'b1; end
            if (d_resp) begin d_read = 1'b0; gd = 1'b1; end
            if (gi && gd) break;
        end
        if (!(gi && gd)) check("pair_timeout", 128'({gd, gi}), 128'd3);
        i_read = 1'b0;
        d_read = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_strobes", 128'({pmem_read, pmem_write}), 128'd0);
        check("rst_addr", 128'(pmem_addr), 128'd0);
        check("rst_wdata", 128'(pmem_wdata), 128'd0);
        check("rst_mbe", 128'(pmem_mbe), 128'd0);
        check("rst_resp", 128'({i_resp, d_resp}), 128'd0);
        check("rst_rdata", 128'({i_rdata, d_rdata}), 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_single(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 2);
        check("d_idle_on_i", 128'(d_resp), 128'd0);
        run_single(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 3);
        run_single(1'b1, 1'b1, 1'b0, 32'h180, 32'h0, 4'hF, 1);
        run_single(1'b1, 1'b1, 1'b1, 32'h1C0, 32'h1234_5678, 4'hC, 2);

        run_pair(32'h0, 32'h200);
        run_single(1'b1, 1'b1, 1'b0, 32'h240, 32'h0, 4'hF, 1);
        run_pair(32'h80, 32'h280);
        run_pair(32'h84, 32'h284);

        for (int n = 0; n < 6; n++) begin
            logic [31:0] a;
            bit s;
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            s = 1'($urandom_range(0, 1));
            run_single(s, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(1, 4));
        end

        // Requester changes address and drops request while busy.
        @(negedge clk);
        mem_lat = 3;
        i_read  = 1'b1;
        i_addr  = 32'h40;
        gnt_q.push_back({1'b1, 1'b0, 32'h40, 32'h0, 4'h0});
        exp_q.push_back({1'b0, mem_data(32'h40)});
        tb_last = 1'b0;
        @(negedge clk);
        i_addr = 32'h44;
        i_read = 1'b0;
        @(negedge clk);
        check("drop_addr", 128'(pmem_addr), 128'h40);
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (i_resp) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            check("drop_resp", 128'(seen), 128'd1);
        end
        repeat (5) @(negedge clk);
        check("rdata_hold", 128'(i_rdata), 128'(mem_data(32'h40)));
        check("drop_no_regrant", 128'({pmem_read, pmem_write}), 128'd0);

        // Reset in the middle of a D-side write; a late pmem_resp must be ignored.
        mem_en = 1'b0;
        @(negedge clk);
        d_write = 1'b1;
        d_addr  = 32'h300;
        d_wdata = 32'hCAFE_F00D;
        d_mbe   = 4'hF;
        gnt_q.push_back({1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 4'hF});
        @(negedge clk);
        check("pre_rst_write", 128'(pmem_write), 128'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_write", 128'(pmem_write), 128'd0);
        check("async_rst_addr", 128'(pmem_addr), 128'd0);
        check("async_rst_mbe", 128'(pmem_mbe), 128'd0);
        d_write = 1'b0;
        tb_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        manual_resp = 1'b1;
        @(negedge clk);
        manual_resp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stale_resp", 128'({d_resp, i_resp}), 128'd0);
        end
        mem_en = 1'b1;

        run_single(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 2);
        run_pair(32'h10, 32'h210);

        repeat (4) @(negedge clk);
        check("gnt_q_left", 128'(gnt_q.size()), 128'd0);
        check("exp_q_left", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
